// File: rtl/exec_stage_mc.sv
// Execute stage: forwarding mux, single-cycle ALU, and an iterative shift-add unsigned multiply.
// Latency: ALU ops 1 edge. MUL commits on the first we=1 edge at or after accept+DATA_W+1.
// Backpressure: we=0 holds every output register; busy tells upstream to hold its inputs during MUL.
module exec_stage_mc #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_N      = 2,
    parameter int SEL_W      = $clog2(FWD_N + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic                    valid_in,
    input  logic [3:0]              aluop,
    input  logic                    alusrc,
    input  logic [DATA_W-1:0]       reg1_data,
    input  logic [DATA_W-1:0]       reg2_data,
    input  logic [DATA_W-1:0]       immediat,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    input  logic [SEL_W-1:0]        forward_src1,
    input  logic [SEL_W-1:0]        forward_src2,
    input  logic [REG_ADDR_W-1:0]   dst_reg_in,
    input  logic                    regwrite_in,
    input  logic                    do_read,
    input  logic                    do_write,
    input  logic                    is_byte,
    input  logic                    memtoreg,
    output logic                    busy,
    output logic                    valid_out,
    output logic [DATA_W-1:0]       alu_result,
    output logic [DATA_W-1:0]       data_store,
    output logic                    zero,
    output logic                    overflow,
    output logic [REG_ADDR_W-1:0]   dst_reg,
    output logic                    regwrite_out,
    output logic                    do_read_out,
    output logic                    do_write_out,
    output logic                    is_byte_out,
    output logic                    memtoreg_out
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       op1, fwd2, op2;
    logic [DATA_W-1:0]       alu_res, add_res, sub_res;
    logic                    alu_ovf;
    logic [SH_W-1:0]         shamt;

    logic [2*DATA_W-1:0]     mcand_q, acc_q;
    logic [DATA_W-1:0]       mplier_q;
    logic [SH_W-1:0]         cnt_q;
    logic [DATA_W-1:0]       mul_store_q;
    logic [REG_ADDR_W-1:0]   mul_dst_q;
    logic                    mul_rw_q, mul_rd_q, mul_wr_q, mul_byte_q, mul_m2r_q;

    // Out-of-range selects fall back to register data so the mux never yields X.
    always_comb begin
        op1  = reg1_data;
        fwd2 = reg2_data;
        for (int k = 0; k < FWD_N; k++) begin
            if (forward_src1 == SEL_W'(k + 1)) op1  = fwd_data[k*DATA_W +: DATA_W];
            if (forward_src2 == SEL_W'(k + 1)) fwd2 = fwd_data[k*DATA_W +: DATA_W];
        end
    end

    assign op2     = alusrc ? fwd2 : immediat;
    assign shamt   = op2[SH_W-1:0];
    assign add_res = op1 + op2;
    assign sub_res = op1 - op2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluop)
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (op1[MSB] == op2[MSB]) && (add_res[MSB] != op1[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (op1[MSB] != op2[MSB]) && (sub_res[MSB] != op1[MSB]);
            end
            OP_AND: alu_res = op1 & op2;
            OP_OR:  alu_res = op1 | op2;
            OP_XOR: alu_res = op1 ^ op2;
            OP_NOR: alu_res = ~(op1 | op2);
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLL: alu_res = op1 << shamt;
            OP_SRL: alu_res = op1 >> shamt;
            OP_SRA: alu_res = $signed(op1) >>> shamt;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            valid_out    <= 1'b0;
            alu_result   <= '0;
            data_store   <= '0;
            zero         <= 1'b0;
            overflow     <= 1'b0;
            dst_reg      <= '0;
            regwrite_out <= 1'b0;
            do_read_out  <= 1'b0;
            do_write_out <= 1'b0;
            is_byte_out  <= 1'b0;
            memtoreg_out <= 1'b0;
            mcand_q      <= '0;
            acc_q        <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            mul_store_q  <= '0;
            mul_dst_q    <= '0;
            mul_rw_q     <= 1'b0;
            mul_rd_q     <= 1'b0;
            mul_wr_q     <= 1'b0;
            mul_byte_q   <= 1'b0;
            mul_m2r_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        if (valid_in && aluop != OP_MUL) begin
                            valid_out    <= 1'b1;
                            alu_result   <= alu_res;
                            data_store   <= fwd2;
                            zero         <= (alu_res == '0);
                            overflow     <= alu_ovf;
                            dst_reg      <= dst_reg_in;
                            regwrite_out <= regwrite_in;
                            do_read_out  <= do_read;
                            do_write_out <= do_write;
                            is_byte_out  <= is_byte;
                            memtoreg_out <= memtoreg;
                        end else begin
                            valid_out    <= 1'b0;
                            regwrite_out <= 1'b0;
                            do_read_out  <= 1'b0;
                            do_write_out <= 1'b0;
                            if (valid_in) begin
                                // Snapshot everything the multiply needs; inputs are don't-care until commit.
                                mcand_q     <= {{DATA_W{1'b0}}, op1};
                                mplier_q    <= op2;
                                acc_q       <= '0;
                                cnt_q       <= '0;
                                mul_store_q <= fwd2;
                                mul_dst_q   <= dst_reg_in;
                                mul_rw_q    <= regwrite_in;
                                mul_rd_q    <= do_read;
                                mul_wr_q    <= do_write;
                                mul_byte_q  <= is_byte;
                                mul_m2r_q   <= memtoreg;
                                state       <= RUN;
                            end
                        end
                    end
                end
                RUN: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SH_W'(1);
                    if (cnt_q == SH_W'(DATA_W - 1)) state <= DONE;
                    if (we) begin
                        valid_out    <= 1'b0;
                        regwrite_out <= 1'b0;
                        do_read_out  <= 1'b0;
                        do_write_out <= 1'b0;
                    end
                end
                DONE: begin
                    if (we) begin
                        valid_out    <= 1'b1;
                        alu_result   <= acc_q[DATA_W-1:0];
                        data_store   <= mul_store_q;
                        zero         <= (acc_q[DATA_W-1:0] == '0);
                        overflow     <= |acc_q[2*DATA_W-1:DATA_W];
                        dst_reg      <= mul_dst_q;
                        regwrite_out <= mul_rw_q;
                        do_read_out  <= mul_rd_q;
                        do_write_out <= mul_wr_q;
                        is_byte_out  <= mul_byte_q;
                        memtoreg_out <= mul_m2r_q;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Bench for exec_stage_mc: directed cases plus random traffic, scoreboarded against an arithmetic model.
module tb_exec_stage_mc;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            we = 1'b0, valid_in = 1'b0, alusrc = 1'b0;
    logic [3:0]      aluop = '0;
    logic [DW-1:0]   reg1_data = '0, reg2_data = '0, immediat = '0;
    logic [2*DW-1:0] fwd_data = '0;
    logic [1:0]      forward_src1 = '0, forward_src2 = '0;
    logic [4:0]      dst_reg_in = '0;
    logic            regwrite_in = 0, do_read = 0, do_write = 0, is_byte = 0, memtoreg = 0;
    logic            busy, valid_out, zero, overflow;
    logic [DW-1:0]   alu_result, data_store;
    logic [4:0]      dst_reg;
    logic            regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out;

    exec_stage_mc #(.DATA_W(DW), .REG_ADDR_W(5), .FWD_N(2)) dut (
        .clk(clk), .reset(reset), .we(we), .valid_in(valid_in), .aluop(aluop), .alusrc(alusrc),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .immediat(immediat), .fwd_data(fwd_data),
        .forward_src1(forward_src1), .forward_src2(forward_src2), .dst_reg_in(dst_reg_in),
        .regwrite_in(regwrite_in), .do_read(do_read), .do_write(do_write), .is_byte(is_byte),
        .memtoreg(memtoreg), .busy(busy), .valid_out(valid_out), .alu_result(alu_result),
        .data_store(data_store), .zero(zero), .overflow(overflow), .dst_reg(dst_reg),
        .regwrite_out(regwrite_out), .do_read_out(do_read_out), .do_write_out(do_write_out),
        .is_byte_out(is_byte_out), .memtoreg_out(memtoreg_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] res;
        logic [DW-1:0] store;
        logic          zero;
        logic          ovf;
        logic [4:0]    dst;
        logic          rw, rd, wr, by, m2r;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        o;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0, n_err = 0;
    logic        mul_pend = 1'b0;
    int unsigned mul_ready = 0;
    obs_t        mul_o;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t dut_obs();
        return {valid_out, alu_result, data_store, zero, overflow, dst_reg,
                regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out};
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %h, required %h", nm, cyc, act, req);
        end
    endtask

    task automatic cmp_bit(input string nm, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc %0d: got %b, required %b", nm, cyc, act, req);
        end
    endtask

    // Reference result computed with 64-bit arithmetic: overflow means the true value does not fit.
    function automatic obs_t ref_op(input logic [3:0] op, input logic [DW-1:0] a, b, st,
                                    input logic [4:0] dst, input logic [4:0] sbits);
        obs_t              o;
        longint            sa, sbv, s;
        longint unsigned   p;
        logic [DW-1:0]     r;
        logic              ov;
        sa  = $signed(a);
        sbv = $signed(b);
        r   = '0;
        ov  = 1'b0;
        case (op)
            4'd0: begin s = sa + sbv; r = s[DW-1:0]; ov = (s != longint'($signed(r))); end
            4'd1: begin s = sa - sbv; r = s[DW-1:0]; ov = (s != longint'($signed(r))); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sbv) ? 32'd1 : 32'd0;
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: begin s = sa >>> b[4:0]; r = s[DW-1:0]; end
            4'd10: begin p = {32'd0, a} * {32'd0, b}; r = p[DW-1:0]; ov = (p[2*DW-1:DW] != 0); end
            default: begin r = '0; ov = 1'b0; end
        endcase
        o.valid = 1'b1;
        o.res   = r;
        o.store = st;
        o.zero  = (r == 0);
        o.ovf   = ov;
        o.dst   = dst;
        {o.rw, o.rd, o.wr, o.by, o.m2r} = sbits;
        return o;
    endfunction

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rv, f0, f1);
        if (sel == 2'd1) return f0;
        if (sel == 2'd2) return f1;
        return rv;
    endfunction

    // One clock of stimulus; the model decides what the following edge must commit.
    task automatic step(input logic w, v, input logic [3:0] op, input logic asrc,
                        input logic [DW-1:0] r1, r2, imm, f0, f1,
                        input logic [1:0] s1, s2, input logic [4:0] dst, sbits);
        logic [DW-1:0] o1, o2, st;
        int unsigned   e;
        @(negedge clk);
        cmp_bit("busy", busy, mul_pend);
        we = w; valid_in = v; aluop = op; alusrc = asrc;
        reg1_data = r1; reg2_data = r2; immediat = imm; fwd_data = {f1, f0};
        forward_src1 = s1; forward_src2 = s2; dst_reg_in = dst;
        {regwrite_in, do_read, do_write, is_byte, memtoreg} = sbits;
        e = cyc + 1;
        if (mul_pend) begin
            if (w && e >= mul_ready) begin
                exp_q.push_back('{e, mul_o});
                mul_pend = 1'b0;
            end
        end else if (w && v) begin
            o1 = pick(s1, r1, f0, f1);
            st = pick(s2, r2, f0, f1);
            o2 = asrc ? st : imm;
            if (op == 4'd10) begin
                mul_o     = ref_op(op, o1, o2, st, dst, sbits);
                mul_pend  = 1'b1;
                mul_ready = e + DW + 1;
            end else begin
                exp_q.push_back('{e, ref_op(op, o1, o2, st, dst, sbits)});
            end
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 7);
            1: return 32'hFFFF_FFF8 | $urandom_range(0, 7);
            2: return 32'h8000_0000 ^ $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    task automatic rstep(input logic w, input logic allow_mul);
        logic [3:0] op;
        op = $urandom_range(0, 15);
        if (!allow_mul && op == 4'd10) op = 4'd0;
        step(w, ($urandom_range(0, 4) != 0), op, $urandom_range(0, 1),
             rnd_word(), rnd_word(), rnd_word(), rnd_word(), rnd_word(),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        mul_pend = 1'b0;
        #1;
        cmp("reset_out", dut_obs(), '0);
        cmp_bit("reset_busy", busy, 1'b0);
        we = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops an expectation on its scheduled edge, otherwise expects a bubble or a hold.
    initial begin : monitor
        obs_t  shadow;
        exp_t  it;
        logic  we_s;
        string tag;
        shadow = '0;
        forever begin
            @(posedge clk);
            we_s = we;
            #1;
            if (reset) begin
                shadow = '0;
            end else begin
                if (we_s) begin
                    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                        it = exp_q.pop_front();
                        shadow = it.o;
                        tag = "commit";
                    end else begin
                        shadow.valid = 1'b0;
                        shadow.rw = 1'b0;
                        shadow.rd = 1'b0;
                        shadow.wr = 1'b0;
                        tag = "bubble";
                    end
                end else begin
                    tag = "hold";
                end
                cmp(tag, dut_obs(), shadow);
            end
        end
    end

    initial begin : driver
        #3;
        cmp("reset_init", dut_obs(), '0);
        cmp_bit("reset_init_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // ADD overflow, SUB to zero, forwarding with in-range and out-of-range selects
        step(1, 1, 4'd0, 0, 32'h7FFF_FFFF, 0, 32'd1, 0, 0, 0, 0, 5'd3, 5'b10000);
        step(1, 1, 4'd1, 0, 32'd5, 0, 32'd5, 0, 0, 0, 0, 5'd4, 5'b10000);
        step(1, 1, 4'd3, 1, 32'h99, 32'h55, 0, 32'h3, 32'h10, 2'd2, 2'd1, 5'd5, 5'b01010);
        step(1, 1, 4'd3, 1, 32'h99, 32'h55, 0, 32'h3, 32'h10, 2'd3, 2'd1, 5'd6, 5'b00101);
        step(1, 0, 4'd0, 0, 1, 1, 1, 0, 0, 0, 0, 5'd7, 5'b11111);

        // MUL 0xFFFF * 0x10001 with junk inputs driven while busy
        step(1, 1, 4'd10, 1, 32'h0000_FFFF, 32'h0001_0001, 0, 0, 0, 0, 0, 5'd9, 5'b10000);
        repeat (DW + 1) rstep(1, 1);

        // MUL 0x80000000 * 2 held in DONE with we=0 for three cycles
        step(1, 1, 4'd10, 0, 32'h8000_0000, 0, 32'd2, 0, 0, 0, 0, 5'd11, 5'b10001);
        repeat (DW) rstep(1, 1);
        repeat (3) rstep(0, 1);
        rstep(1, 0);

        // Abort a multiply mid-run, then a plain ADD must commit normally
        step(1, 1, 4'd10, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 0, 5'd12, 5'b11000);
        repeat (11) rstep(1, 1);
        do_reset();
        step(1, 1, 4'd0, 0, 32'd2, 0, 32'd3, 0, 0, 0, 0, 5'd13, 5'b10000);
        step(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'b00000);

        for (int i = 0; i < 600; i++) begin
            rstep(($urandom_range(0, 4) != 0), 1);
            if (i == 300) do_reset();
        end

        for (int i = 0; i < DW + 8; i++) begin
            if (!mul_pend && exp_q.size() == 0) break;
            rstep(1, 0);
        end
        repeat (2) step(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'b00000);

        n_vec++;
        if (exp_q.size() != 0 || mul_pend) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, multiply pending %b, required none", exp_q.size(), mul_pend);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised next-generation execute stage for the 5-stage pipeline, sitting between the decode/register-read and memory stages.
- Selects each operand from register data or one of FWD_N forwarding sources.
- Executes single-cycle ALU ops, plus an iterative multi-cycle unsigned multiply that stalls upstream via busy.
- Registers the result and memory/writeback sideband on each pipeline advance (we).

Parameters:
DATA_W, 32, datapath width (power of 2, >=8)
REG_ADDR_W, 5, register-index width
FWD_N, 2, number of forwarding sources (MEM result, WB result, ...)
SEL_W, $clog2(FWD_N+1), forward-select width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
we  in  1  pipeline advance; 0 holds all output registers
valid_in  in  1  instruction present
aluop  in  4  operation code, see Behaviour
alusrc  in  1  1: operand2 = forwarded reg2; 0: operand2 = immediat
reg1_data  in  DATA_W  register operand 1
reg2_data  in  DATA_W  register operand 2
immediat  in  DATA_W  sign-extended immediate
fwd_data  in  FWD_N*DATA_W  source k at [k*DATA_W +: DATA_W]
forward_src1  in  SEL_W  0: reg1_data; k in 1..FWD_N: source k-1
forward_src2  in  SEL_W  same, for reg2 path
dst_reg_in  in  REG_ADDR_W  destination register
regwrite_in, do_read, do_write, is_byte, memtoreg  in  1 each  sideband
busy  out  1  multiply in flight; upstream must hold its inputs
valid_out  out  1  registered instruction valid
alu_result  out  DATA_W  registered result
data_store  out  DATA_W  registered forwarded reg2 (store data)
zero  out  1  registered result==0
overflow  out  1  registered overflow
dst_reg  out  REG_ADDR_W  registered destination
regwrite_out, do_read_out, do_write_out, is_byte_out, memtoreg_out  out  1 each  registered sideband

Behaviour:
- Reset: all outputs 0; FSM to IDLE; multiply counter/accumulator cleared. Asserting reset mid-multiply aborts it; no result is committed.
- Forward mux: select values > FWD_N pick register data (never X). data_store always takes the forwarded reg2 value, independent of alusrc.
- aluop encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT: signed, result 1/0
  - 7 SLL, 8 SRL, 9 SRA: shift op1 by op2[$clog2(DATA_W)-1:0]
  - 10 MUL: unsigned, low DATA_W bits of product
  - 11-15 reserved: result 0, overflow 0
- overflow: ADD/SUB signed two's-complement overflow; MUL set if upper DATA_W product bits are nonzero; all other ops 0.
- FSM states IDLE, RUN, DONE; busy = (state != IDLE), decoded from registered state.
- IDLE, edge with we=1:
  - valid_in=1, non-MUL: commit result + sideband; valid_out=1.
  - valid_in=0: commit bubble. valid_out, regwrite_out, do_read_out, do_write_out = 0; data outputs hold.
  - valid_in=1, aluop=MUL: latch operands, dst_reg_in and sideband internally; counter=0; commit a bubble to outputs; go to RUN.
- IDLE, edge with we=0: nothing changes and MUL is not accepted.
- RUN:
  - One shift-add step per clock, independent of we.
  - After step DATA_W-1, go to DONE.
  - Each edge with we=1 commits a bubble.
- DONE:
  - Edge with we=1: commit product, zero, overflow and latched sideband; valid_out=1; go to IDLE.
  - we=0: hold in DONE.
- MUL latency: accept at edge T0; result visible after edge T0+DATA_W+1 (when we=1 there); busy high from just after T0 until just after the commit edge.
- Inputs (valid_in, operands, selects) are ignored while busy.
- Forwarded values are sampled only at MUL accept.

Test Plan:
- Reset asserted between clock edges -> all outputs 0 immediately, busy=0.
- DATA_W=32, ADD with reg1=0x7FFFFFFF, imm=1, alusrc=0, we=1 -> alu_result=0x80000000, overflow=1, zero=0, valid_out=1 next edge. SUB 5-5 -> zero=1.
- FWD_N=2, forward_src1=2, fwd_data source1=0x10, reg1=0x99, alusrc=1, forward_src2=1, source0=0x3, OR -> alu_result=0x13, data_store=0x3. forward_src1=3 -> reg1_data used.
- MUL 0x0000FFFF*0x00010001 accepted at T0 -> busy=1; bubbles (valid_out=0) for 32 edges; after edge T0+33: alu_result=0xFFFFFFFF, overflow=0, busy=0, dst_reg=latched value.
- MUL 0x80000000*2 with we=0 held for 3 cycles in DONE -> outputs unchanged until we=1; then alu_result=0, zero=1, overflow=1.
- Reset asserted at RUN step 10 -> FSM IDLE, busy=0, outputs 0. A following ADD 2+3 commits 5 normally.
